data_path: RTL and testbench

DATA_PATH -- requirements
Module: data_path

---
 rtl/data_path_pkg.sv | 19 +
 rtl/data_path_if.sv | 22 ++
 rtl/data_path_alu.sv | 46 ++++
 rtl/data_path.sv | 75 +++++++
 tb/tb_data_path.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/data_path_pkg.sv
// data_path_pkg: shared constants for the data path.
//   DW      - data width of every architectural register and the bus
//   OP_*    - ALU operation codes carried on the SHR port
package data_path_pkg;
   localparam int DW = 32;

   localparam logic [4:0] OP_ADD  = 5'b00011;
   localparam logic [4:0] OP_SUB  = 5'b00100;
   localparam logic [4:0] OP_SHR  = 5'b00101;
   localparam logic [4:0] OP_SHRA = 5'b00110;
   localparam logic [4:0] OP_SHL  = 5'b00111;
   localparam logic [4:0] OP_ROR  = 5'b01000;
   localparam logic [4:0] OP_ROL  = 5'b01001;
   localparam logic [4:0] OP_AND  = 5'b01010;
   localparam logic [4:0] OP_OR   = 5'b01011;
   localparam logic [4:0] OP_NEG  = 5'b01100;
   localparam logic [4:0] OP_NOT  = 5'b01101;
   localparam logic [4:0] OP_MUL  = 5'b01110;
endpackage

// File: rtl/data_path_if.sv
// data_path_if: control/data bundle for the data path.
//   master - control unit side: drives selects, enables, opcode, Mdatain; reads BusMuxOut
//   slave  - data path side: the reverse
interface data_path_if;
   import data_path_pkg::*;
   logic          PCout, ZHighout, Zlowout, MDRout;
   logic [7:2]    Rout;
   logic          MARin, PCin, MDRin, IRin, Yin;
   logic          IncPC, Read;
   logic [4:0]    SHR;
   logic [15:1]   Rin;
   logic          HIin, LOin, ZHighIn, ZLowIn, Cin;
   logic [DW-1:0] Mdatain;
   logic [DW-1:0] BusMuxOut;

   modport master (output PCout, ZHighout, Zlowout, MDRout, Rout, MARin, PCin, MDRin,
                   IRin, Yin, IncPC, Read, SHR, Rin, HIin, LOin, ZHighIn, ZLowIn, Cin,
                   Mdatain, input BusMuxOut);
   modport slave  (input PCout, ZHighout, Zlowout, MDRout, Rout, MARin, PCin, MDRin,
                   IRin, Yin, IncPC, Read, SHR, Rin, HIin, LOin, ZHighIn, ZLowIn, Cin,
                   Mdatain, output BusMuxOut);
endinterface

// File: rtl/data_path_alu.sv
// alu: combinational ALU, A = Y register, B = bus.
//   a_i, b_i  - operands (DW bits)
//   op_i      - operation code (OP_* in data_path_pkg)
//   cin_i     - carry-in for ADD / borrow-in for SUB
//   res_o     - 64-bit result; upper half nonzero only for MUL
module alu
   import data_path_pkg::*;
(
   input  logic [DW-1:0]   a_i,
   input  logic [DW-1:0]   b_i,
   input  logic [4:0]      op_i,
   input  logic            cin_i,
   output logic [2*DW-1:0] res_o
);
   logic [4:0]          sh;
   logic [2*DW-1:0]     aa, ror_w, rol_w;
   logic [DW-1:0]       sra_w;
   logic signed [2*DW-1:0] prod;

   assign sh    = b_i[4:0];
   // Rotates done on the doubled operand so shift-by-0 falls out naturally.
   assign aa    = {a_i, a_i};
   assign ror_w = aa >> sh;
   assign rol_w = aa << sh;
   assign sra_w = $signed(a_i) >>> sh;
   assign prod  = $signed(a_i) * $signed(b_i);

   always_comb begin
      res_o = '0;
      case (op_i)
         OP_ADD:  res_o[DW-1:0] = a_i + b_i + {{(DW-1){1'b0}}, cin_i};
         OP_SUB:  res_o[DW-1:0] = a_i - b_i - {{(DW-1){1'b0}}, cin_i};
         OP_SHR:  res_o[DW-1:0] = a_i >> sh;
         OP_SHRA: res_o[DW-1:0] = sra_w;
         OP_SHL:  res_o[DW-1:0] = a_i << sh;
         OP_ROR:  res_o[DW-1:0] = ror_w[DW-1:0];
         OP_ROL:  res_o[DW-1:0] = rol_w[2*DW-1:DW];
         OP_AND:  res_o[DW-1:0] = a_i & b_i;
         OP_OR:   res_o[DW-1:0] = a_i | b_i;
         OP_NEG:  res_o[DW-1:0] = -b_i;
         OP_NOT:  res_o[DW-1:0] = ~b_i;
         OP_MUL:  res_o         = prod;
         default: res_o         = '0;
      endcase
   end
endmodule

// File: rtl/data_path.sv
// data_path: single-bus register file + ALU data path.
//   *out selects   - drive bus (PC > ZHigh > ZLow > MDR > R2..R7), none -> 0
//   *in enables    - load bus into the register on rising Clock
//   IncPC / Read   - PC increment; MDR source (1 = Mdatain, 0 = bus)
//   SHR            - ALU opcode; Cin - ALU carry-in
//   Clock / Clear  - clock; async active-low clear of all storage
//   Mdatain        - memory read data; BusMuxOut - current bus value
module data_path
   import data_path_pkg::*;
(
   input  logic          PCout, ZHighout, Zlowout, MDRout,
   input  logic          R2out, R3out, R4out, R5out, R6out, R7out,
   input  logic          MARin, PCin, MDRin, IRin, Yin,
   input  logic          IncPC, Read,
   input  logic [4:0]    SHR,
   input  logic          R1in, R2in, R3in, R4in, R5in, R6in, R7in, R8in,
   input  logic          R9in, R10in, R11in, R12in, R13in, R14in, R15in,
   input  logic          HIin, LOin, ZHighIn, ZLowIn, Cin,
   input  logic          Clock, Clear,
   input  logic [DW-1:0] Mdatain,
   output logic [DW-1:0] BusMuxOut
);
   logic [15:1][DW-1:0] r_q;
   logic [DW-1:0]       pc_q, ir_q, mar_q, mdr_q, y_q, hi_q, lo_q;
   logic [2*DW-1:0]     z_q, alu_res;
   logic [15:1]         rin;
   logic [DW-1:0]       bus;

   assign rin = {R15in, R14in, R13in, R12in, R11in, R10in, R9in, R8in,
                 R7in, R6in, R5in, R4in, R3in, R2in, R1in};

   always_comb begin
      bus = '0;
      if      (PCout)    bus = pc_q;
      else if (ZHighout) bus = z_q[2*DW-1:DW];
      else if (Zlowout)  bus = z_q[DW-1:0];
      else if (MDRout)   bus = mdr_q;
      else if (R2out)    bus = r_q[2];
      else if (R3out)    bus = r_q[3];
      else if (R4out)    bus = r_q[4];
      else if (R5out)    bus = r_q[5];
      else if (R6out)    bus = r_q[6];
      else if (R7out)    bus = r_q[7];
   end
   assign BusMuxOut = bus;

   alu u_alu (.a_i(y_q), .b_i(bus), .op_i(SHR), .cin_i(Cin), .res_o(alu_res));

   always_ff @(posedge Clock or negedge Clear) begin
      if (!Clear) begin
         r_q   <= '0;
         pc_q  <= '0;
         ir_q  <= '0;
         mar_q <= '0;
         mdr_q <= '0;
         y_q   <= '0;
         hi_q  <= '0;
         lo_q  <= '0;
         z_q   <= '0;
      end else begin
         for (int i = 1; i <= 15; i++)
            if (rin[i]) r_q[i] <= bus;
         if (PCin)       pc_q <= bus;
         else if (IncPC) pc_q <= pc_q + 1'b1;
         if (IRin)    ir_q  <= bus;
         if (MARin)   mar_q <= bus;
         if (MDRin)   mdr_q <= Read ? Mdatain : bus;
         if (Yin)     y_q   <= bus;
         if (HIin)    hi_q  <= bus;
         if (LOin)    lo_q  <= bus;
         if (ZLowIn)  z_q[DW-1:0]    <= alu_res[DW-1:0];
         if (ZHighIn) z_q[2*DW-1:DW] <= alu_res[2*DW-1:DW];
      end
   end
endmodule

// File: tb/tb_data_path.sv
module tb_data_path;
   import data_path_pkg::*;

   logic Clock = 1'b0;
   logic Clear;
   int   tot_cnt = 0;
   int   pass_cnt = 0;

   data_path_if dif ();

   always #5 Clock = ~Clock;

   data_path dut (
      .PCout(dif.PCout), .ZHighout(dif.ZHighout), .Zlowout(dif.Zlowout), .MDRout(dif.MDRout),
      .R2out(dif.Rout[2]), .R3out(dif.Rout[3]), .R4out(dif.Rout[4]),
      .R5out(dif.Rout[5]), .R6out(dif.Rout[6]), .R7out(dif.Rout[7]),
      .MARin(dif.MARin), .PCin(dif.PCin), .MDRin(dif.MDRin), .IRin(dif.IRin), .Yin(dif.Yin),
      .IncPC(dif.IncPC), .Read(dif.Read), .SHR(dif.SHR),
      .R1in(dif.Rin[1]), .R2in(dif.Rin[2]), .R3in(dif.Rin[3]), .R4in(dif.Rin[4]),
      .R5in(dif.Rin[5]), .R6in(dif.Rin[6]), .R7in(dif.Rin[7]), .R8in(dif.Rin[8]),
      .R9in(dif.Rin[9]), .R10in(dif.Rin[10]), .R11in(dif.Rin[11]), .R12in(dif.Rin[12]),
      .R13in(dif.Rin[13]), .R14in(dif.Rin[14]), .R15in(dif.Rin[15]),
      .HIin(dif.HIin), .LOin(dif.LOin), .ZHighIn(dif.ZHighIn), .ZLowIn(dif.ZLowIn), .Cin(dif.Cin),
      .Clock(Clock), .Clear(Clear), .Mdatain(dif.Mdatain), .BusMuxOut(dif.BusMuxOut)
   );

   task automatic idle();
      dif.PCout = 0; dif.ZHighout = 0; dif.Zlowout = 0; dif.MDRout = 0; dif.Rout = '0;
      dif.MARin = 0; dif.PCin = 0; dif.MDRin = 0; dif.IRin = 0; dif.Yin = 0;
      dif.IncPC = 0; dif.Read = 0; dif.SHR = '0; dif.Rin = '0;
      dif.HIin = 0; dif.LOin = 0; dif.ZHighIn = 0; dif.ZLowIn = 0; dif.Cin = 0;
      dif.Mdatain = '0;
   endtask

   // One clock edge, then drop all controls and let things settle.
   task automatic tick();
      @(posedge Clock); #1;
      idle(); #1;
   endtask

   // Memory value -> MDR -> (register selected by rsel / Y when rsel==0).
   task automatic put(input logic [31:0] v, input int rsel);
      dif.Mdatain = v; dif.Read = 1; dif.MDRin = 1; tick();
      dif.MDRout = 1;
      if (rsel == 0) dif.Yin = 1; else dif.Rin[rsel] = 1;
      tick();
   endtask

   // Y op R4 -> Z (both halves).
   task automatic alu_op(input logic [4:0] op, input logic cin);
      dif.Rout[4] = 1; dif.SHR = op; dif.Cin = cin; dif.ZLowIn = 1; dif.ZHighIn = 1; tick();
   endtask

   task automatic test_reset();
      idle(); Clear = 0; #2;
      dif.PCout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL reset_pc: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      dif.PCout = 0; dif.ZHighout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL reset_zhi: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      dif.ZHighout = 0; dif.Rout[7] = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL reset_r7: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      idle();
      @(negedge Clock); Clear = 1; #1;
   endtask

   task automatic test_load();
      dif.Mdatain = 32'h12; dif.Read = 1; dif.MDRin = 1; tick();
      dif.MDRout = 1; dif.Rin[2] = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h12) $display("FAIL load_drive: got %h exp %h", dif.BusMuxOut, 32'h12); else pass_cnt++;
      tick();
      dif.Rout[2] = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h12) $display("FAIL load_r2: got %h exp %h", dif.BusMuxOut, 32'h12); else pass_cnt++;
      // MDR from bus when Read=0
      dif.Rout[2] = 1; dif.MDRin = 1; dif.Mdatain = 32'hDEAD; tick();
      dif.MDRout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h12) $display("FAIL mdr_from_bus: got %h exp %h", dif.BusMuxOut, 32'h12); else pass_cnt++;
      idle();
   endtask

   task automatic test_shr();
      put(32'h14, 3); put(32'h18, 1);
      dif.Rout[2] = 1; dif.Yin = 1; tick();
      dif.Rout[3] = 1; dif.SHR = OP_SHR; dif.ZLowIn = 1; tick();
      dif.Zlowout = 1; dif.Rin[1] = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL shr_by20: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      tick();
   endtask

   task automatic test_alu_ops();
      logic [4:0]  ops [12] = '{OP_SHR, OP_SHRA, OP_ROR, OP_SHL, OP_ROL, OP_AND,
                               OP_OR, OP_NEG, OP_NOT, OP_SUB, 5'b00000, 5'b11111};
      logic [31:0] exp [12] = '{32'h08000001, 32'hF8000001, 32'h08000001, 32'h00000100,
                               32'h00000108, 32'h00000000, 32'h80000014, 32'hFFFFFFFC,
                               32'hFFFFFFFB, 32'h8000000C, 32'h00000000, 32'h00000000};
      put(32'h80000010, 0); put(32'h4, 4);
      for (int i = 0; i < 12; i++) begin
         alu_op(ops[i], 1'b0);
         dif.Zlowout = 1; #1;
         tot_cnt++; if (dif.BusMuxOut !== exp[i]) $display("FAIL alu_op_%b: got %h exp %h", ops[i], dif.BusMuxOut, exp[i]); else pass_cnt++;
         dif.Zlowout = 0; dif.ZHighout = 1; #1;
         tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL alu_hi_%b: got %h exp %h", ops[i], dif.BusMuxOut, 32'h0); else pass_cnt++;
         idle();
      end
      // shift/rotate amount taken from B[4:0] only: 0x20 -> shift by 0
      put(32'h20, 4);
      alu_op(OP_SHRA, 1'b0); dif.Zlowout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h80000010) $display("FAIL shra_by0: got %h exp %h", dif.BusMuxOut, 32'h80000010); else pass_cnt++;
      idle();
      alu_op(OP_ROL, 1'b0); dif.Zlowout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h80000010) $display("FAIL rol_by0: got %h exp %h", dif.BusMuxOut, 32'h80000010); else pass_cnt++;
      idle();
   endtask

   task automatic test_mul_add();
      put(32'hFFFFFFFE, 0); put(32'h3, 4);
      alu_op(OP_MUL, 1'b0);
      dif.Zlowout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'hFFFFFFFA) $display("FAIL mul_lo: got %h exp %h", dif.BusMuxOut, 32'hFFFFFFFA); else pass_cnt++;
      dif.Zlowout = 0; dif.ZHighout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'hFFFFFFFF) $display("FAIL mul_hi: got %h exp %h", dif.BusMuxOut, 32'hFFFFFFFF); else pass_cnt++;
      idle();
      put(32'h5, 0); put(32'h7, 4);
      alu_op(OP_ADD, 1'b1); dif.Zlowout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'hD) $display("FAIL add_cin: got %h exp %h", dif.BusMuxOut, 32'hD); else pass_cnt++;
      idle();
      put(32'hFFFFFFFF, 0); put(32'h1, 4);
      alu_op(OP_ADD, 1'b0); dif.Zlowout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL add_wrap: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      idle();
      put(32'h0, 0);
      alu_op(OP_SUB, 1'b1); dif.Zlowout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'hFFFFFFFE) $display("FAIL sub_wrap: got %h exp %h", dif.BusMuxOut, 32'hFFFFFFFE); else pass_cnt++;
      idle();
   endtask

   task automatic test_pc();
      dif.Mdatain = 32'h7; dif.Read = 1; dif.MDRin = 1; tick();
      dif.MDRout = 1; dif.PCin = 1; tick();
      dif.PCout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h7) $display("FAIL pc_load: got %h exp %h", dif.BusMuxOut, 32'h7); else pass_cnt++;
      dif.MARin = 1; dif.IncPC = 1; tick();
      dif.PCout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h8) $display("FAIL pc_inc: got %h exp %h", dif.BusMuxOut, 32'h8); else pass_cnt++;
      idle();
      dif.MDRout = 1; dif.PCin = 1; dif.IncPC = 1; tick();
      dif.PCout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h7) $display("FAIL pcin_wins: got %h exp %h", dif.BusMuxOut, 32'h7); else pass_cnt++;
      idle();
      dif.Mdatain = 32'hFFFFFFFF; dif.Read = 1; dif.MDRin = 1; tick();
      dif.MDRout = 1; dif.PCin = 1; tick();
      dif.IncPC = 1; tick();
      dif.PCout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL pc_wrap: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      idle();
   endtask

   task automatic test_priority();
      put(32'hA5, 5);              // MDR=A5, R5=A5
      put(32'h3C, 6);              // MDR=3C, R6=3C
      dif.Rout[5] = 1; dif.Rout[6] = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'hA5) $display("FAIL prio_r5_r6: got %h exp %h", dif.BusMuxOut, 32'hA5); else pass_cnt++;
      dif.MDRout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h3C) $display("FAIL prio_mdr_r5: got %h exp %h", dif.BusMuxOut, 32'h3C); else pass_cnt++;
      dif.PCout = 1; dif.Zlowout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL prio_pc: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      idle(); #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL no_select: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      // multi-load and drive+load in the same edge: R5 drives, R5/R6/R7 load
      dif.Rout[5] = 1; dif.Rin[5] = 1; dif.Rin[6] = 1; dif.Rin[7] = 1; tick();
      dif.Rout[6] = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'hA5) $display("FAIL multi_r6: got %h exp %h", dif.BusMuxOut, 32'hA5); else pass_cnt++;
      idle(); dif.Rout[7] = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'hA5) $display("FAIL multi_r7: got %h exp %h", dif.BusMuxOut, 32'hA5); else pass_cnt++;
      idle();
      // Y drives ALU while loading: Y=2, bus=R4 ... use Y<=Y+bus via Z
      put(32'h2, 0); put(32'h3, 4);
      dif.Rout[4] = 1; dif.SHR = OP_ADD; dif.ZLowIn = 1; dif.Yin = 1; tick();
      dif.Zlowout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h5) $display("FAIL pre_edge_y: got %h exp %h", dif.BusMuxOut, 32'h5); else pass_cnt++;
      idle();
   endtask

   task automatic test_reset_mid();
      put(32'h55, 2);
      dif.Rout[2] = 1; dif.Rin[3] = 1; dif.PCin = 1;
      @(posedge Clock); #2;
      Clear = 0; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL clr_async_r2: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      idle(); dif.Mdatain = 32'h77; dif.Read = 1; dif.MDRin = 1; dif.Rin = '1;
      @(posedge Clock); #1;
      dif.Rin = '0; dif.MDRin = 0; dif.MDRout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL clr_hold_mdr: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      idle();
      @(negedge Clock); Clear = 1;
      dif.Mdatain = 32'h99; dif.Read = 1; dif.MDRin = 1; tick();
      dif.MDRout = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h99) $display("FAIL post_clr_load: got %h exp %h", dif.BusMuxOut, 32'h99); else pass_cnt++;
      idle(); dif.Rout[3] = 1; #1;
      tot_cnt++; if (dif.BusMuxOut !== 32'h0) $display("FAIL post_clr_r3: got %h exp %h", dif.BusMuxOut, 32'h0); else pass_cnt++;
      idle();
   endtask

   initial begin
      Clear = 0;
      idle();
      test_reset();
      test_load();
      test_shr();
      test_alu_ops();
      test_mul_add();
      test_pc();
      test_priority();
      test_reset_mid();
      $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
      $finish;
   end
endmodule
